// File: rtl/reg_file.sv
// 32-entry general-purpose register file: two async read ports, one
// synchronous write port, a debug read port, optional write-through.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int SP_IDX = 29,
  parameter logic [DATA_W-1:0] SP_INIT = 128,
  parameter int BYPASS = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic              reg_write_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic [DATA_W-1:0] dbg_data_o
);

  localparam int DEPTH = 1 << ADDR_W;

  // Entry 0 has no storage; it is the hardwired zero register.
  logic [DATA_W-1:0] regs [1:DEPTH-1];

  logic wr_en;
  logic byp_en;
  logic rs_hit;
  logic rt_hit;

  assign wr_en  = reg_write_i && (rd_addr_i != '0);
  assign byp_en = (BYPASS != 0) && rst_i && wr_en;
  assign rs_hit = byp_en && (rs_addr_i == rd_addr_i);
  assign rt_hit = byp_en && (rt_addr_i == rd_addr_i);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 1; i < DEPTH; i++) begin
        regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
      end
    end else if (wr_en) begin
      regs[rd_addr_i] <= rd_data_i;
    end
  end

  function automatic logic [DATA_W-1:0] stored(
    input logic [ADDR_W-1:0] addr
  );
    if (addr == '0) begin
      return '0;
    end
    return regs[addr];
  endfunction

  always_comb begin
    rs_data_o  = stored(rs_addr_i);
    rt_data_o  = stored(rt_addr_i);
    dbg_data_o = stored(dbg_addr_i);
    if (rs_hit) begin
      rs_data_o = rd_data_i;
    end
    if (rt_hit) begin
      rt_data_o = rd_data_i;
    end
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- 32 x 32-bit general-purpose register file for the single-cycle CPU.
- Sits directly upstream of the ALU. rs_data_o drives the ALU src1_i; rt_data_o drives src2_i through the ALUSrc mux.
- Accepts the write-back result (ALU result_o or memory data) at the clock edge.
- Two asynchronous read ports, one synchronous write port, one debug read port for benches.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; depth = 2^ADDR_W.
- SP_IDX, 29, index of the stack-pointer register given a non-zero reset value.
- SP_INIT, 128, reset value of register SP_IDX.
- BYPASS, 1, when 1 a read of the register being written in the same cycle returns the write data (write-through); when 0 it returns the old contents.

Ports:
- clk_i  in  1  system clock; all state updates on rising edge.
- rst_i  in  1  synchronous reset, active-low; sampled on rising edge of clk_i.
- rs_addr_i  in  ADDR_W  read port A index (instruction rs field).
- rt_addr_i  in  ADDR_W  read port B index (instruction rt field).
- rd_addr_i  in  ADDR_W  write index (rd or rt, selected upstream by RegDst).
- rd_data_i  in  DATA_W  write-back data.
- reg_write_i  in  1  write enable.
- dbg_addr_i  in  ADDR_W  debug read index.
- rs_data_o  out  DATA_W  read port A data to ALU src1_i.
- rt_data_o  out  DATA_W  read port B data to ALU src2_i mux / store data.
- dbg_data_o  out  DATA_W  debug read data (never bypassed).

Behaviour:
- Storage: 2^ADDR_W registers of DATA_W bits.
- Register 0 is hardwired to zero: never stored, always reads 0, and writes to index 0 are discarded.
- Reset: on a rising edge with rst_i==0, every register becomes 0 except SP_IDX, which becomes SP_INIT. Reset has priority over any simultaneous write; that write is lost.
- Reset is synchronous only. Asserting rst_i between edges changes nothing until the next rising edge.
- Outputs carry no flops. After reset, each output equals the reset contents of its addressed register: 0, or SP_INIT for SP_IDX.
- Write: on a rising edge with rst_i==1, reg_write_i==1 and rd_addr_i!=0, the addressed register takes rd_data_i. Written data is visible from the following cycle.
- Read: rs_data_o, rt_data_o and dbg_data_o are combinational functions of their address and the current contents, so read latency is 0 cycles. The ALU sees operands in the same cycle the instruction is decoded.
- Bypass, BYPASS==1: if reg_write_i==1, rd_addr_i!=0 and rs_addr_i==rd_addr_i, then rs_data_o = rd_data_i. The rt port behaves identically and independently; both ports may bypass at once.
- Bypass never applies to index 0, nor while rst_i==0; during reset the outputs show stored contents.
- BYPASS==0: reads always return stored contents.
- rs_addr_i==rt_addr_i is legal; both ports return identical data.
- reg_write_i==0 leaves all contents unchanged regardless of rd_addr_i and rd_data_i.
- Any DATA_W value may be written; there is no sign or width conversion.
- No X propagation from unwritten entries: reset initialises every entry.

Test Plan:
- Reset: hold rst_i=0 for 2 edges, then rst_i=1. Sweep dbg_addr_i 0..31 and check dbg_data_o = 0 everywhere except index 29 = 128. With rs_addr_i=29, rs_data_o=128.
- Write/read: write 0xDEADBEEF to r8, then 0x00000005 to r9 on consecutive edges. Next cycle, rs_addr_i=8, rt_addr_i=9 gives rs_data_o=0xDEADBEEF, rt_data_o=0x00000005.
- Zero register: reg_write_i=1, rd_addr_i=0, rd_data_i=0xFFFFFFFF, clock. rs_data_o at address 0 stays 0 both in the write cycle (no bypass) and after it.
- Bypass: BYPASS=1, r10 holds 0x11. Drive rd_addr_i=10, rd_data_i=0x22, reg_write_i=1, rs_addr_i=rt_addr_i=10: both outputs read 0x22 before the edge and after it. With BYPASS=0, both read 0x11 before the edge and 0x22 after.
- Reset vs write: r12=0x7, then same edge rst_i=0, reg_write_i=1, rd_addr_i=12, rd_data_i=0x99. After the edge, r12=0 and r29=128.
- Write-enable low: reg_write_i=0, rd_addr_i=5, rd_data_i=0xABCD for 3 edges. r5 keeps its prior value 0, confirmed via dbg port.
